gmm_update_model_pipe: RTL and testbench

- Stage directly downstream of the GMM distance/match stage in gmm_fg_detector.
- Consumes mega_data_t carrying per-pixel model state (mem_w, mem_color, mem_var), the squared distances (vars), var_min_idx and is_matched.
- Applies the running-average model update: reinforces the matched cluster, decays the others, and creates or replaces a cluster when nothing matched.
- Emits the same mega_data_t with mem_* and in.clusters_num overwritten by the updated model, ready for write-back to model memory.

---
 rtl/gmm_structures_pkg.sv | 65 ++++++
 rtl/gmm_update_model_pipe_cluster.sv | 60 ++++++
 rtl/gmm_update_model_pipe.sv | 132 +++++++++++++
 tb/tb_gmm_update_model_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmm_structures_pkg.sv
// gmm_structures: shared types for the GMM foreground detector.
//   mega_data_t : one pixel beat (input pixel, per-cluster model, match result)
//   cluster_t   : one model cluster (weight, colour, variance)
//   upd_mode_t  : per-cluster update action chosen by the update stage
//   s1_t, s2_t  : internal pipeline registers of gmm_update_model_pipe
package gmm_structures;

   localparam int GMM_MAX_CLUSTERS = 3;
   localparam int VARS_W           = 20;  // squared RGB distance needs 18 bits; headroom kept

   typedef struct packed {
      logic [2:0][7:0] color;
   } rgb_t;

   typedef struct packed {
      rgb_t       rgb_new;
      logic [1:0] clusters_num;
   } pix_in_t;

   typedef struct packed {
      pix_in_t                                          in;
      logic [GMM_MAX_CLUSTERS-1:0][7:0]                 mem_w;
      logic [GMM_MAX_CLUSTERS-1:0][2:0][7:0]            mem_color;
      logic [GMM_MAX_CLUSTERS-1:0][15:0]                mem_var;
      logic [GMM_MAX_CLUSTERS-1:0][VARS_W-1:0]          vars;
      logic [1:0]                                       var_min_idx;
      logic                                             is_matched;
      logic [VARS_W-1:0]                                var_min;
      logic [VARS_W-1:0]                                var_max;
      logic [1:0]                                       B;
   } mega_data_t;

   // 'var' is a keyword, so the variance field is spelled out.
   typedef struct packed {
      logic [7:0]      w;
      logic [2:0][7:0] color;
      logic [15:0]     variance;
   } cluster_t;

   typedef enum logic [1:0] {UPD_MATCH, UPD_DECAY, UPD_NEW, UPD_KEEP} upd_mode_t;

   typedef struct packed {
      mega_data_t      d;
      logic [1:0]      t;
      logic            match;
      logic [2:0][7:0] x;
      logic [15:0]     vclamp;
   } s1_t;

   typedef struct packed {
      mega_data_t                       d;
      cluster_t [GMM_MAX_CLUSTERS-1:0]  cl;
      logic [1:0]                       n_new;
   } s2_t;

   // Index of the lightest cluster; strict compares keep the lowest index on ties.
   function automatic logic [1:0] min_w_idx(input logic [GMM_MAX_CLUSTERS-1:0][7:0] w);
      logic [1:0] idx;
      idx = 2'd0;
      if (w[1] < w[idx]) idx = 2'd1;
      if (w[2] < w[idx]) idx = 2'd2;
      return idx;
   endfunction

endpackage

// File: rtl/gmm_update_model_pipe_cluster.sv
// gmm_update_cluster: combinational update of a single GMM cluster.
//   cl_i     : current cluster state
//   mode_i   : MATCH (reinforce), DECAY, NEW (create/replace), KEEP
//   x_i      : pixel colour
//   vclamp_i : squared distance to the target cluster, saturated to 16 bits
//   cl_o     : updated cluster state
module gmm_update_cluster
   import gmm_structures::*;
#(
   parameter int          ALPHA_SH = 5,
   parameter logic [7:0]  W_INIT   = 8'd16,
   parameter logic [15:0] VAR_INIT = 16'd900,
   parameter logic [15:0] VAR_MIN  = 16'd16
) (
   input  cluster_t        cl_i,
   input  upd_mode_t       mode_i,
   input  logic [2:0][7:0] x_i,
   input  logic [15:0]     vclamp_i,
   output cluster_t        cl_o
);

   logic [7:0]         w_inc, w_dec;
   logic [2:0][7:0]    c_upd;
   logic signed [16:0] dv;
   logic [15:0]        v_sum, v_upd;

   assign w_inc = cl_i.w + ((8'd255 - cl_i.w) >> ALPHA_SH);
   assign w_dec = cl_i.w - (cl_i.w >> ALPHA_SH);

   // The true result always lies between the old value and the target, so
   // truncating the signed step to the field width and adding modulo 2^N is exact.
   for (genvar c = 0; c < 3; c++) begin : g_c
      logic signed [8:0] dc;
      assign dc       = $signed({1'b0, x_i[c]}) - $signed({1'b0, cl_i.color[c]});
      assign c_upd[c] = cl_i.color[c] + 8'(dc >>> ALPHA_SH);
   end

   assign dv    = $signed({1'b0, vclamp_i}) - $signed({1'b0, cl_i.variance});
   assign v_sum = cl_i.variance + 16'(dv >>> ALPHA_SH);
   assign v_upd = (v_sum < VAR_MIN) ? VAR_MIN : v_sum;

   always_comb begin
      cl_o = cl_i;
      unique case (mode_i)
         UPD_MATCH: begin
            cl_o.w        = w_inc;
            cl_o.color    = c_upd;
            cl_o.variance = v_upd;
         end
         UPD_DECAY: cl_o.w = w_dec;
         UPD_NEW: begin
            cl_o.w        = W_INIT;
            cl_o.color    = x_i;
            cl_o.variance = VAR_INIT;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/gmm_update_model_pipe.sv
// gmm_update_model_pipe: 3-stage GMM model update with valid/ready handshake.
//   snk_valid/snk_data/snk_ready : incoming beat with model and match result
//   src_valid/src_data/src_ready : outgoing beat with updated model
// Stage 1 picks the target cluster, stage 2 updates every cluster, stage 3
// folds the result back into the beat.
module gmm_update_model_pipe
   import gmm_structures::*;
#(
   parameter int          ALPHA_SH = 5,
   parameter logic [7:0]  W_INIT   = 8'd16,
   parameter logic [15:0] VAR_INIT = 16'd900,
   parameter logic [15:0] VAR_MIN  = 16'd16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          snk_valid,
   input  logic [$bits(mega_data_t)-1:0] snk_data,
   output logic                          snk_ready,
   input  logic                          src_ready,
   output logic                          src_valid,
   output logic [$bits(mega_data_t)-1:0] src_data
);

   localparam logic [1:0] NMAX = 2'(GMM_MAX_CLUSTERS);

   logic [3:1] vld_q, vld_d;
   logic       rdy1, rdy2, rdy3;
   s1_t        s1_q, s1_d;
   s2_t        s2_q, s2_d;
   mega_data_t s3_q, s3_d;

   mega_data_t in_beat;
   logic [1:0] n_in, t_in, n_new;
   logic       match_in;
   cluster_t   cl_cur [GMM_MAX_CLUSTERS];
   cluster_t   cl_upd [GMM_MAX_CLUSTERS];
   upd_mode_t  mode   [GMM_MAX_CLUSTERS];

   // Handshake: a stage can take a beat if it is empty or its beat moves on.
   always_comb begin
      rdy3  = src_ready | ~vld_q[3];
      rdy2  = rdy3 | ~vld_q[2];
      rdy1  = rdy2 | ~vld_q[1];
      vld_d = vld_q;
      if (rdy1) vld_d[1] = snk_valid;
      if (rdy2) vld_d[2] = vld_q[1];
      if (rdy3) vld_d[3] = vld_q[2];
   end

   // Stage 1: classification.
   always_comb begin
      in_beat  = mega_data_t'(snk_data);
      n_in     = in_beat.in.clusters_num;
      match_in = in_beat.is_matched & (n_in != 2'd0);
      if (match_in)         t_in = in_beat.var_min_idx;
      else if (n_in < NMAX) t_in = n_in;
      else                  t_in = min_w_idx(in_beat.mem_w);
      s1_d = s1_q;
      if (snk_valid & rdy1) begin
         s1_d.d      = in_beat;
         s1_d.t      = t_in;
         s1_d.match  = match_in;
         s1_d.x      = in_beat.in.rgb_new.color;
         s1_d.vclamp = (|in_beat.vars[t_in][VARS_W-1:16]) ? 16'hFFFF : in_beat.vars[t_in][15:0];
      end
   end

   // Stage 2: per-cluster arithmetic.
   assign n_new = s1_q.match ? s1_q.d.in.clusters_num :
                  (s1_q.d.in.clusters_num == NMAX) ? NMAX : s1_q.d.in.clusters_num + 2'd1;

   for (genvar k = 0; k < GMM_MAX_CLUSTERS; k++) begin : g_cl
      assign cl_cur[k] = {s1_q.d.mem_w[k], s1_q.d.mem_color[k], s1_q.d.mem_var[k]};
      assign mode[k]   = (2'(k) >= n_new)  ? UPD_KEEP :
                         (2'(k) == s1_q.t) ? (s1_q.match ? UPD_MATCH : UPD_NEW) :
                                             UPD_DECAY;
      gmm_update_cluster #(
         .ALPHA_SH (ALPHA_SH),
         .W_INIT   (W_INIT),
         .VAR_INIT (VAR_INIT),
         .VAR_MIN  (VAR_MIN)
      ) u_cl (
         .cl_i     (cl_cur[k]),
         .mode_i   (mode[k]),
         .x_i      (s1_q.x),
         .vclamp_i (s1_q.vclamp),
         .cl_o     (cl_upd[k])
      );
   end

   always_comb begin
      s2_d = s2_q;
      if (vld_q[1] & rdy2) begin
         s2_d.d     = s1_q.d;
         s2_d.n_new = n_new;
         for (int k = 0; k < GMM_MAX_CLUSTERS; k++) s2_d.cl[k] = cl_upd[k];
      end
   end

   // Stage 3: write the updated model back into the beat.
   always_comb begin
      s3_d = s3_q;
      if (vld_q[2] & rdy3) begin
         s3_d                 = s2_q.d;
         s3_d.in.clusters_num = s2_q.n_new;
         for (int k = 0; k < GMM_MAX_CLUSTERS; k++) begin
            s3_d.mem_w[k]     = s2_q.cl[k].w;
            s3_d.mem_color[k] = s2_q.cl[k].color;
            s3_d.mem_var[k]   = s2_q.cl[k].variance;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
      end else begin
         vld_q <= vld_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         s3_q  <= s3_d;
      end
   end

   assign snk_ready = rdy1;
   assign src_valid = vld_q[3];
   assign src_data  = s3_q;

endmodule

// File: tb/tb_gmm_update_model_pipe.sv
module tb_gmm_update_model_pipe;
   import gmm_structures::*;

   localparam int          ALPHA_SH = 5;
   localparam logic [7:0]  W_INIT   = 8'd16;
   localparam logic [15:0] VAR_INIT = 16'd900;
   localparam int          VAR_MIN  = 16;
   localparam int          MW       = $bits(mega_data_t);

   logic       clk = 1'b0;
   logic       rst, snk_valid, snk_ready, src_ready, src_valid;
   mega_data_t snk_data, src_data;

   int         checks = 0, fails = 0, npop = 0;
   mega_data_t exp_q[$];
   mega_data_t last_out, held, e_mon;
   bit         hold_pend = 0;

   always #5 clk = ~clk;

   gmm_update_model_pipe #(
      .ALPHA_SH (ALPHA_SH),
      .W_INIT   (W_INIT),
      .VAR_INIT (VAR_INIT),
      .VAR_MIN  (16'(VAR_MIN))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .snk_valid (snk_valid),
      .snk_data  (snk_data),
      .snk_ready (snk_ready),
      .src_ready (src_ready),
      .src_valid (src_valid),
      .src_data  (src_data)
   );

   task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int fdiv(input int a, input int d);
      int q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q--;
      return q;
   endfunction

   // Reference: the update rules in plain integer arithmetic.
   function automatic mega_data_t model(input mega_data_t b);
      mega_data_t o;
      int n, t, nn, w, v, vc, div;
      bit m;
      div = 1 << ALPHA_SH;
      o = b;
      n = b.in.clusters_num;
      m = b.is_matched && (n != 0);
      if (m) t = b.var_min_idx;
      else if (n < 3) t = n;
      else begin
         t = 0;
         for (int k = 1; k < 3; k++) if (b.mem_w[k] < b.mem_w[t]) t = k;
      end
      nn = m ? n : ((n < 3) ? n + 1 : 3);
      vc = (b.vars[t] > 65535) ? 65535 : int'(b.vars[t]);
      for (int k = 0; k < nn; k++) begin
         w = b.mem_w[k];
         if (k != t) o.mem_w[k] = 8'(w - w / div);
         else if (!m) begin
            o.mem_w[k]     = W_INIT;
            o.mem_color[k] = b.in.rgb_new.color;
            o.mem_var[k]   = VAR_INIT;
         end else begin
            o.mem_w[k] = 8'(w + (255 - w) / div);
            for (int c = 0; c < 3; c++)
               o.mem_color[k][c] = 8'(int'(b.mem_color[k][c]) +
                  fdiv(int'(b.in.rgb_new.color[c]) - int'(b.mem_color[k][c]), div));
            v = int'(b.mem_var[k]) + fdiv(vc - int'(b.mem_var[k]), div);
            if (v < VAR_MIN) v = VAR_MIN;
            o.mem_var[k] = 16'(v);
         end
      end
      o.in.clusters_num = 2'(nn);
      return o;
   endfunction

   function automatic mega_data_t rand_beat();
      logic [MW-1:0] r;
      mega_data_t b;
      for (int i = 0; i < MW; i++) r[i] = 1'($urandom_range(0, 1));
      b = r;
      b.var_min_idx = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) b.mem_w[2] = b.mem_w[1];
      if ($urandom_range(0, 3) == 0) b.mem_w[1] = b.mem_w[0];
      if ($urandom_range(0, 3) == 0) begin
         b.mem_var[b.var_min_idx] = 16'($urandom_range(0, 40));
         b.vars[b.var_min_idx]    = 20'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 3) == 0) b.vars[b.var_min_idx] = 20'($urandom_range(60000, 70000));
      return b;
   endfunction

   // Scoreboard and hold-stable monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) hold_pend = 0;
      else begin
         if (hold_pend) begin
            chk("hold_valid", src_valid, 1);
            chk("hold_data", src_data, held);
         end
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 32'(exp_q.size()), 1);
            else begin
               e_mon = exp_q.pop_front();
               chk("out", src_data, e_mon);
            end
            last_out = src_data;
            npop++;
         end
         hold_pend = src_valid && !src_ready;
         held      = src_data;
         if (snk_valid && snk_ready) exp_q.push_back(model(snk_data));
      end
   end

   task automatic send(input mega_data_t b);
      bit acc;
      int g;
      g = 0;
      snk_valid = 1;
      snk_data  = b;
      do begin
         @(negedge clk);
         acc = snk_ready;
         @(posedge clk); #1;
         g++;
      end while (!acc && g < 200);
      if (!acc) chk("send_timeout", acc, 1);
      snk_valid = 0;
   endtask

   task automatic xact(input mega_data_t b, output mega_data_t o);
      int p, g;
      p = npop;
      g = 0;
      src_ready = 1;
      send(b);
      while (npop == p && g < 20) begin @(posedge clk); #1; g++; end
      if (npop == p) chk("xact_timeout", npop, p + 1);
      o = last_out;
   endtask

   task automatic drain();
      int g;
      g = 0;
      snk_valid = 0;
      src_ready = 1;
      while (exp_q.size() > 0 && g < 40) begin @(posedge clk); #1; g++; end
      chk("drain_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      mega_data_t b, o;
      mega_data_t bp [8];
      int idx;
      bit acc;

      rst = 1; snk_valid = 0; src_ready = 0; snk_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_src_valid", src_valid, 0);
      chk("rst_src_data", src_data, 0);
      rst = 0; src_ready = 1;
      #1 chk("rst_snk_ready", snk_ready, 1);

      // Match / reinforcement
      b = '0;
      b.in.clusters_num = 2; b.var_min_idx = 0; b.is_matched = 1;
      b.mem_w[0] = 128; b.mem_w[1] = 64;
      b.mem_color[0][0] = 100; b.mem_color[0][1] = 100; b.mem_color[0][2] = 100;
      b.in.rgb_new.color[0] = 132; b.in.rgb_new.color[1] = 68; b.in.rgb_new.color[2] = 100;
      b.mem_var[0] = 1000; b.vars[0] = 3000; b.vars[1] = 20'h12345;
      xact(b, o);
      chk("m_w0", o.mem_w[0], 131);
      chk("m_w1", o.mem_w[1], 62);
      chk("m_c0", o.mem_color[0][0], 101);
      chk("m_c1", o.mem_color[0][1], 99);
      chk("m_c2", o.mem_color[0][2], 100);
      chk("m_var0", o.mem_var[0], 1062);
      chk("m_n", o.in.clusters_num, 2);
      chk("m_pass_vars", o.vars, b.vars);

      // Variance rounding and clamps
      b = '0;
      b.in.clusters_num = 1; b.is_matched = 1; b.mem_var[0] = 20; b.vars[0] = 1;
      xact(b, o);
      chk("v_small", o.mem_var[0], 19);
      b.mem_var[0] = 16; b.vars[0] = 0;
      xact(b, o);
      chk("v_min_clamp", o.mem_var[0], 16);
      b.mem_var[0] = 1000; b.vars[0] = 200000;
      xact(b, o);
      chk("v_sat", o.mem_var[0], 3016);

      // Create
      b = '0;
      b.in.clusters_num = 2; b.is_matched = 0; b.mem_w[0] = 128; b.mem_w[1] = 64;
      b.in.rgb_new.color[0] = 10; b.in.rgb_new.color[1] = 20; b.in.rgb_new.color[2] = 30;
      xact(b, o);
      chk("c_w2", o.mem_w[2], 16);
      chk("c_col2", o.mem_color[2], {8'd30, 8'd20, 8'd10});
      chk("c_var2", o.mem_var[2], 900);
      chk("c_w0", o.mem_w[0], 124);
      chk("c_w1", o.mem_w[1], 62);
      chk("c_n", o.in.clusters_num, 3);
      b = '0;
      b.in.clusters_num = 0; b.is_matched = 1; b.mem_var[0] = 5;
      xact(b, o);
      chk("c0_w0", o.mem_w[0], 16);
      chk("c0_var0", o.mem_var[0], 900);
      chk("c0_n", o.in.clusters_num, 1);

      // Replace, tie resolves to lowest index
      b = '0;
      b.in.clusters_num = 3; b.is_matched = 0;
      b.mem_w[0] = 40; b.mem_w[1] = 10; b.mem_w[2] = 10;
      xact(b, o);
      chk("r_w1", o.mem_w[1], 16);
      chk("r_var1", o.mem_var[1], 900);
      chk("r_w0", o.mem_w[0], 39);
      chk("r_w2", o.mem_w[2], 10);
      chk("r_n", o.in.clusters_num, 3);
      drain();

      // Backpressure: only three beats fit while the sink is stalled
      for (int i = 0; i < 8; i++) bp[i] = rand_beat();
      src_ready = 0; idx = 0;
      for (int c = 0; c < 10; c++) begin
         snk_valid = 1; snk_data = bp[idx];
         @(negedge clk); if (snk_ready) idx++;
         @(posedge clk); #1;
      end
      chk("bp_accepted", idx, 3);
      chk("bp_snk_ready", snk_ready, 0);
      src_ready = 1;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         snk_valid = 1; snk_data = bp[idx];
         @(negedge clk); if (snk_ready) idx++;
         @(posedge clk); #1;
      end
      chk("bp_all_sent", idx, 8);
      drain();

      // Reset with a full pipeline, then first-beat latency
      src_ready = 0;
      for (int i = 0; i < 3; i++) send(rand_beat());
      rst = 1;
      #1;
      chk("mid_rst_valid", src_valid, 0);
      chk("mid_rst_data", src_data, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 0; src_ready = 1;
      send(rand_beat());
      chk("lat_c1", src_valid, 0);
      @(posedge clk); #1;
      chk("lat_c2", src_valid, 0);
      @(posedge clk); #1;
      chk("lat_c3", src_valid, 1);
      drain();

      // Random traffic with random backpressure
      acc = 1;
      for (int c = 0; c < 600; c++) begin
         src_ready = ($urandom_range(0, 3) != 0);
         if (acc) begin
            snk_valid = ($urandom_range(0, 3) != 0);
            snk_data  = rand_beat();
         end
         @(negedge clk);
         acc = !snk_valid || snk_ready;
         @(posedge clk); #1;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
